// File: rtl/mem_stage_if.sv
// Memory-buffer side of the MEM stage: held-level read/write requests out,
// zero-extended load data and the one-cycle done pulse back.
interface mem_stage_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32
);
   logic [1:0]        mem_read_req;
   logic [1:0]        mem_write_req;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_write_data;
   logic [DATA_W-1:0] mem_data_i;
   logic              mem_data_enable;

   modport master (
      output mem_read_req, mem_write_req, mem_addr_o, mem_write_data,
      input  mem_data_i, mem_data_enable
   );

   modport slave (
      input  mem_read_req, mem_write_req, mem_addr_o, mem_write_data,
      output mem_data_i, mem_data_enable
   );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: turns EX load/store ops into byte-serial buffer requests.
// Optional macro MEM_STAGE_MISALIGN_EN: reject misaligned half/word accesses, flag on misalign_o.
module mem_stage #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              ex_load,
   input  logic              ex_store,
   input  logic [2:0]        ex_funct3,
   input  logic [31:0]       ex_addr,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [4:0]        ex_wd,
   input  logic              ex_wreg,
   input  logic [DATA_W-1:0] ex_wdata,
   mem_stage_if.master       mem,
   output logic              wb_valid,
   output logic [4:0]        wb_wd,
   output logic              wb_wreg,
   output logic [DATA_W-1:0] wb_wdata,
`ifdef MEM_STAGE_MISALIGN_EN
   output logic              misalign_o,
`endif
   output logic              stall_req
);

   typedef enum logic [1:0] {IDLE, BUSY_LD, BUSY_ST} state_t;

   state_t            state_q, state_d;
   logic [1:0]        rd_req_q, rd_req_d;
   logic [1:0]        wr_req_q, wr_req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] st_data_q, st_data_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        ld_wd_q, ld_wd_d;
   logic              ld_wreg_q, ld_wreg_d;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_wd_q, wb_wd_d;
   logic              wb_wreg_q, wb_wreg_d;
   logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
   logic              misalign_q, misalign_d;

   logic              ld_ok, st_ok, misaligned;
   logic [1:0]        size_code;
   logic [DATA_W-1:0] ld_ext;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^ex_addr[31:ADDR_W];

   assign ld_ok = ex_load & ~ex_store &
                  ((ex_funct3 == 3'b000) | (ex_funct3 == 3'b001) | (ex_funct3 == 3'b010) |
                   (ex_funct3 == 3'b100) | (ex_funct3 == 3'b101));
   assign st_ok = ex_store & ~ex_load &
                  ((ex_funct3 == 3'b000) | (ex_funct3 == 3'b001) | (ex_funct3 == 3'b010));
   // funct3[1:0] 00/01/10 maps onto request codes 01/10/11
   assign size_code = ex_funct3[1:0] + 2'd1;

`ifdef MEM_STAGE_MISALIGN_EN
   assign misaligned = ((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                       ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      ld_ext = mem.mem_data_i;
      case (funct3_q)
         3'b000:  ld_ext = {{(DATA_W-8){mem.mem_data_i[7]}}, mem.mem_data_i[7:0]};
         3'b001:  ld_ext = {{(DATA_W-16){mem.mem_data_i[15]}}, mem.mem_data_i[15:0]};
         3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, mem.mem_data_i[7:0]};
         3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, mem.mem_data_i[15:0]};
         default: ld_ext = mem.mem_data_i;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      rd_req_d   = rd_req_q;
      wr_req_d   = wr_req_q;
      addr_d     = addr_q;
      st_data_d  = st_data_q;
      funct3_d   = funct3_q;
      ld_wd_d    = ld_wd_q;
      ld_wreg_d  = ld_wreg_q;
      wb_valid_d = 1'b0;
      wb_wd_d    = wb_wd_q;
      wb_wreg_d  = wb_wreg_q;
      wb_wdata_d = wb_wdata_q;
      misalign_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!ex_valid) begin
               wb_wreg_d = 1'b0;
            end else if ((ld_ok | st_ok) && !misaligned) begin
               addr_d    = ex_addr[ADDR_W-1:0];
               funct3_d  = ex_funct3;
               ld_wd_d   = ex_wd;
               ld_wreg_d = ex_wreg;
               wb_wreg_d = 1'b0;
               if (ld_ok) begin
                  rd_req_d = size_code;
                  state_d  = BUSY_LD;
               end else begin
                  wr_req_d  = size_code;
                  st_data_d = ex_store_data;
                  state_d   = BUSY_ST;
               end
            end else begin
               // ALU op passes through; rejected memory ops pass through without a write
               wb_valid_d = 1'b1;
               wb_wd_d    = ex_wd;
               wb_wreg_d  = ex_wreg & ~ex_load & ~ex_store;
               wb_wdata_d = ex_wdata;
               misalign_d = ld_ok | st_ok;
            end
         end
         BUSY_LD, BUSY_ST: begin
            if (mem.mem_data_enable) begin
               rd_req_d   = 2'b00;
               wr_req_d   = 2'b00;
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_wd_d    = ld_wd_q;
               if (state_q == BUSY_LD) begin
                  wb_wreg_d  = ld_wreg_q;
                  wb_wdata_d = ld_ext;
               end else begin
                  wb_wreg_d  = 1'b0;
                  wb_wdata_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_req_q   <= '0;
         wr_req_q   <= '0;
         addr_q     <= '0;
         st_data_q  <= '0;
         funct3_q   <= '0;
         ld_wd_q    <= '0;
         ld_wreg_q  <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_wd_q    <= '0;
         wb_wreg_q  <= 1'b0;
         wb_wdata_q <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_req_q   <= rd_req_d;
         wr_req_q   <= wr_req_d;
         addr_q     <= addr_d;
         st_data_q  <= st_data_d;
         funct3_q   <= funct3_d;
         ld_wd_q    <= ld_wd_d;
         ld_wreg_q  <= ld_wreg_d;
         wb_valid_q <= wb_valid_d;
         wb_wd_q    <= wb_wd_d;
         wb_wreg_q  <= wb_wreg_d;
         wb_wdata_q <= wb_wdata_d;
         misalign_q <= misalign_d;
      end
   end

   assign mem.mem_read_req   = rd_req_q;
   assign mem.mem_write_req  = wr_req_q;
   assign mem.mem_addr_o     = addr_q;
   assign mem.mem_write_data = st_data_q;
   assign wb_valid           = wb_valid_q;
   assign wb_wd              = wb_wd_q;
   assign wb_wreg            = wb_wreg_q;
   assign wb_wdata           = wb_wdata_q;
   assign stall_req          = (state_q != IDLE);
`ifdef MEM_STAGE_MISALIGN_EN
   assign misalign_o         = misalign_q;
`else
   logic unused_misalign;
   assign unused_misalign = misalign_q;
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage. Sits between the EX stage and the byte-serial memory buffer.
- Converts EX load/store micro-ops into the buffer's held-level read/write requests (01 byte, 10 half, 11 word). It waits for the buffer's one-cycle done pulse, then sign- or zero-extends load data.
- Stalls the pipeline while a transfer is outstanding and registers results towards write-back.

Parameters:
- ADDR_W, 17, width of the RAM address sent to the memory buffer.
- DATA_W, 32, register/data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX presents an instruction this cycle
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store
- ex_funct3  in  3  RISC-V funct3 of the load/store
- ex_addr  in  32  effective address
- ex_store_data  in  32  rs2 value for stores
- ex_wd  in  5  destination register
- ex_wreg  in  1  destination write enable
- ex_wdata  in  32  ALU result (non-memory ops)
- mem_read_req  out  2  to buffer: 00 none, 01 byte, 10 half, 11 word
- mem_write_req  out  2  to buffer, same encoding
- mem_addr_o  out  ADDR_W  access address to buffer
- mem_write_data  out  32  store data to buffer
- mem_data_i  in  32  zero-extended load data from buffer
- mem_data_enable  in  1  buffer done pulse (load data valid / store complete)
- wb_valid  out  1  one-cycle pulse: wb_* outputs are valid
- wb_wd  out  5  destination register to write-back
- wb_wreg  out  1  write-back enable
- wb_wdata  out  32  write-back data
- stall_req  out  1  pipeline stall request

Behaviour:
- Reset (async, rst=1): state=IDLE; both req=00; mem_addr_o=0; mem_write_data=0; wb_valid=0; wb_wd=0; wb_wreg=0; wb_wdata=0. Reset while BUSY drops the request immediately; no completion is reported.
- States: IDLE, BUSY_LD, BUSY_ST. stall_req = (state != IDLE), combinational from state only.
- IDLE, ex_valid=0: wb_valid<=0, wb_wreg<=0.
- IDLE, ex_valid=1, neither ex_load nor ex_store:
  - next edge: wb_valid<=1, wb_wd<=ex_wd, wb_wreg<=ex_wreg, wb_wdata<=ex_wdata.
  - Latency 1 cycle.
- IDLE, ex_load=1 with legal funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU):
  - latch mem_addr_o<=ex_addr[ADDR_W-1:0], wd, wreg, funct3.
  - mem_read_req <= 01/10/11 for byte/half/word.
  - go BUSY_LD; wb_valid<=0.
- IDLE, ex_store=1 with legal funct3 (000 SB, 001 SH, 010 SW):
  - latch address and mem_write_data<=ex_store_data.
  - mem_write_req <= 01/10/11.
  - go BUSY_ST; wb_valid<=0.
- Illegal funct3, or ex_load and ex_store both 1: no request; one-cycle pass-through with wb_wreg forced 0.
- BUSY_x:
  - ex_* inputs ignored; upstream holds them stable because stall_req=1.
  - Requests and address held constant every cycle until done.
- BUSY_x, edge where mem_data_enable=1:
  - req<=00; state<=IDLE; wb_valid<=1.
  - Load: wb_wreg<=latched wreg; wb_wdata = LB {24{d[7]},d[7:0]}, LH {16{d[15]},d[15:0]}, LW d, LBU/LHU zero-extended.
  - Store: wb_wreg<=0, wb_wdata<=0.
  - Load-to-result latency = buffer latency + 1 edge. stall_req falls the cycle after the done pulse.
- mem_data_enable while IDLE is ignored (stray or late pulse).
- A new instruction is accepted only in IDLE. Back-to-back memory ops therefore leave at least one IDLE cycle between requests, so the buffer sees req=00 and clears its busy flag before the next request.
- Address is truncated to ADDR_W bits; upper bits are not checked.
- Only the low 2 bits of req are significant. Read and write requests are never both non-zero.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_EN.
- Defined:
  - extra output misalign_o (1 bit, reset 0).
  - In IDLE, a load/store with LH/LHU/SH and addr[0]=1, or LW/SW and addr[1:0]!=0, issues no request.
  - Instead: one-cycle pass-through with wb_wreg=0, and misalign_o pulses 1 for that cycle alongside wb_valid.
- Not defined: no port; misaligned accesses are issued to the buffer unchanged.

Test Plan:
- Reset while BUSY_LD with mem_read_req=11 -> req is 00 immediately (async), stall_req=0, wb_valid never pulses; after release, an ALU op (wdata=0x12345678, wd=5) gives wb_valid=1, wb_wdata=0x12345678 one edge later.
- LB at 0x00104, buffer returns 0x000000F0 after 3 cycles -> mem_read_req=01, mem_addr_o=0x00104 held throughout; wb_wdata=0xFFFFFFF0, wb_wreg=1, stall_req high through the done cycle then low.
- LHU then LH at the same address, buffer data 0x00008001 -> wb_wdata=0x00008001, then 0xFFFF8001; one IDLE cycle with req=00 between the two requests.
- SW 0xDEADBEEF at 0x00200 -> mem_write_req=11, mem_write_data=0xDEADBEEF until the pulse; wb_valid=1 with wb_wreg=0; mem_read_req stays 00.
- Spurious mem_data_enable in IDLE, then SB -> no wb_valid from the spurious pulse; SB proceeds normally with mem_write_req=01.
- With MEM_STAGE_MISALIGN_EN: LW at 0x00102 -> no request, misalign_o=1 and wb_valid=1 for one cycle, wb_wreg=0. Without the macro: mem_read_req=11 is issued at 0x00102.
